// File: rtl/fpu_ss_pkg.sv
// ---------------------------------------------------------------------------
// fpu_ss_pkg : shared types and constants for the FPU subsystem write-back path
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_ss_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [ADDR_WIDTH-1:0] fp_reg_addr_t;

  typedef enum logic [0:0] {
    WB_FPU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/fpu_ss_scoreboard.sv
// ---------------------------------------------------------------------------
// fpu_ss_scoreboard : per-register pending-write flags with issue/source lookup
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumRegs   = NUM_REGS,
  parameter int unsigned AddrWidth = $clog2(NumRegs)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      set_en_i,
  input  logic [AddrWidth-1:0]      set_addr_i,
  input  logic                      clr_en_i,
  input  logic [AddrWidth-1:0]      clr_addr_i,
  input  logic [AddrWidth-1:0]      issue_addr_i,
  output logic                      issue_busy_o,
  input  logic [2:0][AddrWidth-1:0] rs_addr_i,
  output logic [2:0]                rs_busy_o
);

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_next;

  // Set is applied after clear so a re-issue to the retiring register stays busy.
  always_comb begin
    w_busy_next = r_busy;
    if (clr_en_i) w_busy_next[clr_addr_i] = 1'b0;
    if (set_en_i) w_busy_next[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_busy <= '0;
    else         r_busy <= w_busy_next;
  end

  assign issue_busy_o = r_busy[issue_addr_i];

  for (genvar k = 0; k < 3; k++) begin : g_rs_lookup
    assign rs_busy_o[k] = r_busy[rs_addr_i[k]];
  end

endmodule

`default_nettype wire

// File: rtl/fpu_ss_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_ss_wb_arbiter : FPU/load write-back arbiter, write stage and scoreboard
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_ss_wb_arbiter
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NumRegs   = NUM_REGS,
  parameter int unsigned AddrWidth = $clog2(NumRegs),
  parameter int unsigned DataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fpu_valid_i,
  output logic                      fpu_ready_o,
  input  logic [AddrWidth-1:0]      fpu_rd_i,
  input  logic [DataWidth-1:0]      fpu_wdata_i,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic [AddrWidth-1:0]      mem_rd_i,
  input  logic [DataWidth-1:0]      mem_wdata_i,
  input  logic                      issue_valid_i,
  input  logic [AddrWidth-1:0]      issue_rd_i,
  output logic                      issue_ready_o,
  input  logic [2:0][AddrWidth-1:0] rs_addr_i,
  output logic [2:0]                rs_busy_o,
  output logic                      we_o,
  output logic [AddrWidth-1:0]      waddr_o,
  output logic [DataWidth-1:0]      wdata_o
);

  wb_src_e              r_ptr;
  logic                 r_we;
  logic [AddrWidth-1:0] r_waddr;
  logic [DataWidth-1:0] r_wdata;

  logic w_fpu_gnt;
  logic w_mem_gnt;
  logic w_contended;
  logic w_issue_busy;

  // Grants look only at valids and the pointer, never at downstream readies.
  assign w_contended = fpu_valid_i & mem_valid_i;
  assign w_fpu_gnt   = fpu_valid_i & (~mem_valid_i | (r_ptr == WB_FPU));
  assign w_mem_gnt   = mem_valid_i & (~fpu_valid_i | (r_ptr == WB_MEM));

  assign fpu_ready_o = w_fpu_gnt;
  assign mem_ready_o = w_mem_gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= WB_FPU;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_fpu_gnt | w_mem_gnt;
      if (w_contended) r_ptr <= (r_ptr == WB_FPU) ? WB_MEM : WB_FPU;
      if (w_fpu_gnt) begin
        r_waddr <= fpu_rd_i;
        r_wdata <= fpu_wdata_i;
      end else if (w_mem_gnt) begin
        r_waddr <= mem_rd_i;
        r_wdata <= mem_wdata_i;
      end
    end
  end

  assign we_o    = r_we;
  assign waddr_o = r_waddr;
  assign wdata_o = r_wdata;

  assign issue_ready_o = ~w_issue_busy;

  fpu_ss_scoreboard #(
    .NumRegs   (NumRegs),
    .AddrWidth (AddrWidth)
  ) u_scoreboard (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .set_en_i     (issue_valid_i & issue_ready_o),
    .set_addr_i   (issue_rd_i),
    .clr_en_i     (r_we),
    .clr_addr_i   (r_waddr),
    .issue_addr_i (issue_rd_i),
    .issue_busy_o (w_issue_busy),
    .rs_addr_i    (rs_addr_i),
    .rs_busy_o    (rs_busy_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_fpu_ss_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_ss_wb_arbiter : directed table, reset sequence and randomized model check
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_ss_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic             fpu_valid, fpu_ready;
  logic [4:0]       fpu_rd;
  logic [31:0]      fpu_wdata;
  logic             mem_valid, mem_ready;
  logic [4:0]       mem_rd;
  logic [31:0]      mem_wdata;
  logic             issue_valid, issue_ready;
  logic [4:0]       issue_rd;
  logic [2:0][4:0]  rs_addr;
  logic [2:0]       rs_busy;
  logic             we;
  logic [4:0]       waddr;
  logic [31:0]      wdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter #(
    .NumRegs   (32),
    .AddrWidth (5),
    .DataWidth (32)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fpu_valid_i   (fpu_valid),
    .fpu_ready_o   (fpu_ready),
    .fpu_rd_i      (fpu_rd),
    .fpu_wdata_i   (fpu_wdata),
    .mem_valid_i   (mem_valid),
    .mem_ready_o   (mem_ready),
    .mem_rd_i      (mem_rd),
    .mem_wdata_i   (mem_wdata),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .rs_addr_i     (rs_addr),
    .rs_busy_o     (rs_busy),
    .we_o          (we),
    .waddr_o       (waddr),
    .wdata_o       (wdata)
  );

  typedef struct {
    logic        fv;  logic [4:0] frd; logic [31:0] fd;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic        iv;  logic [4:0] ird; logic [4:0]  rs0;
    logic        efr; logic       emr; logic        ewe;
    logic [4:0]  ewa; logic [31:0] ewd;
    logic        eir; logic       ers0;
  } vec_t;

  function automatic vec_t mk(
    input logic fv, input logic [4:0] frd, input logic [31:0] fd,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic iv, input logic [4:0] ird, input logic [4:0] rs0,
    input logic efr, input logic emr, input logic ewe,
    input logic [4:0] ewa, input logic [31:0] ewd,
    input logic eir, input logic ers0);
    vec_t v;
    v.fv = fv; v.frd = frd; v.fd = fd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.iv = iv; v.ird = ird; v.rs0 = rs0; v.efr = efr; v.emr = emr; v.ewe = ewe;
    v.ewa = ewa; v.ewd = ewd; v.eir = eir; v.ers0 = ers0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fpu_valid = 1'b0; fpu_rd = '0; fpu_wdata = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_wdata = '0;
    issue_valid = 1'b0; issue_rd = '0; rs_addr = '0;
  endtask

  localparam logic [31:0] ONE = 32'h3F80_0000;
  localparam logic [31:0] A1  = 32'hA1A1_0001;
  localparam logic [31:0] B2  = 32'hB2B2_0002;
  localparam logic [31:0] C3  = 32'hC3C3_0003;
  localparam logic [31:0] D4  = 32'hD4D4_0004;
  localparam logic [31:0] L7  = 32'h7777_0007;
  localparam logic [31:0] F3  = 32'hF3F3_0033;
  localparam logic [31:0] N9  = 32'h9999_0009;

  vec_t vecs[21];

  // Reference model state for the randomized phase
  bit          m_busy[32];
  int          m_turn;        // 0: fpu wins the next contention, 1: mem wins
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  initial begin
    vecs[0]  = mk(1,5,ONE, 0,0,0,  0,0,0, 1,0,0,0,0,   1,0);
    vecs[1]  = mk(0,0,0,   0,0,0,  0,0,0, 0,0,1,5,ONE, 1,0);
    vecs[2]  = mk(0,0,0,   0,0,0,  0,0,0, 0,0,0,5,ONE, 1,0);
    vecs[3]  = mk(1,1,A1,  1,2,B2, 0,0,0, 1,0,0,5,ONE, 1,0);
    vecs[4]  = mk(0,0,0,   1,2,B2, 0,0,0, 0,1,1,1,A1,  1,0);
    vecs[5]  = mk(1,3,C3,  1,4,D4, 0,0,0, 0,1,1,2,B2,  1,0);
    vecs[6]  = mk(1,3,C3,  0,0,0,  0,0,0, 1,0,1,4,D4,  1,0);
    vecs[7]  = mk(0,0,0,   0,0,0,  0,0,0, 0,0,1,3,C3,  1,0);
    vecs[8]  = mk(0,0,0,   0,0,0,  1,7,7, 0,0,0,3,C3,  1,0);
    vecs[9]  = mk(0,0,0,   0,0,0,  0,7,7, 0,0,0,3,C3,  0,1);
    vecs[10] = mk(0,0,0,   1,7,L7, 0,7,7, 0,1,0,3,C3,  0,1);
    vecs[11] = mk(0,0,0,   0,0,0,  0,7,7, 0,0,1,7,L7,  0,1);
    vecs[12] = mk(0,0,0,   0,0,0,  0,7,7, 0,0,0,7,L7,  1,0);
    vecs[13] = mk(0,0,0,   0,0,0,  1,3,3, 0,0,0,7,L7,  1,0);
    vecs[14] = mk(0,0,0,   0,0,0,  1,3,3, 0,0,0,7,L7,  0,1);
    vecs[15] = mk(1,3,F3,  0,0,0,  1,3,3, 1,0,0,7,L7,  0,1);
    vecs[16] = mk(0,0,0,   0,0,0,  1,3,3, 0,0,1,3,F3,  0,1);
    vecs[17] = mk(0,0,0,   0,0,0,  1,3,3, 0,0,0,3,F3,  1,0);
    vecs[18] = mk(1,9,N9,  0,0,0,  0,9,9, 1,0,0,3,F3,  1,0);
    vecs[19] = mk(0,0,0,   0,0,0,  1,9,9, 0,0,1,9,N9,  1,0);
    vecs[20] = mk(0,0,0,   0,0,0,  0,9,9, 0,0,0,9,N9,  0,1);

    // Reset values, with an fpu request showing that ready follows valid
    idle_inputs();
    rst_ni    = 1'b0;
    fpu_valid = 1'b1;
    #1;
    chk("reset we",          32'(we),          32'd0);
    chk("reset waddr",       32'(waddr),       32'd0);
    chk("reset wdata",       wdata,            32'd0);
    chk("reset fpu_ready",   32'(fpu_ready),   32'd1);
    chk("reset mem_ready",   32'(mem_ready),   32'd0);
    chk("reset issue_ready", 32'(issue_ready), 32'd1);
    chk("reset rs_busy",     32'(rs_busy),     32'd0);
    fpu_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;

    // Directed table
    for (int i = 0; i < 21; i++) begin
      fpu_valid = vecs[i].fv; fpu_rd = vecs[i].frd; fpu_wdata = vecs[i].fd;
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_wdata = vecs[i].md;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
      rs_addr = {5'd0, 5'd0, vecs[i].rs0};
      @(negedge clk);
      chk($sformatf("row%0d fpu_ready", i),   32'(fpu_ready),   32'(vecs[i].efr));
      chk($sformatf("row%0d mem_ready", i),   32'(mem_ready),   32'(vecs[i].emr));
      chk($sformatf("row%0d we", i),          32'(we),          32'(vecs[i].ewe));
      chk($sformatf("row%0d waddr", i),       32'(waddr),       32'(vecs[i].ewa));
      chk($sformatf("row%0d wdata", i),       wdata,            vecs[i].ewd);
      chk($sformatf("row%0d issue_ready", i), 32'(issue_ready), 32'(vecs[i].eir));
      chk($sformatf("row%0d rs_busy", i),     32'(rs_busy),     {29'd0, 2'b00, vecs[i].ers0});
      @(posedge clk); #1;
    end

    // Reset in flight: busy[3] and busy[9] set, pointer moved to mem, write captured
    idle_inputs();
    fpu_valid = 1'b1; fpu_rd = 5'd12; fpu_wdata = 32'hDEAD_BEEF;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_wdata = 32'h1313_1313;
    @(negedge clk);
    chk("inflight fpu_ready", 32'(fpu_ready), 32'd1);
    chk("inflight mem_ready", 32'(mem_ready), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("inflight we", 32'(we), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("async reset we",    32'(we),    32'd0);
    chk("async reset waddr", 32'(waddr), 32'd0);
    chk("async reset wdata", wdata,      32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    issue_rd = 5'd3;
    rs_addr  = {5'd12, 5'd9, 5'd3};
    #1;
    chk("post reset issue_ready r3", 32'(issue_ready), 32'd1);
    chk("post reset rs_busy",        32'(rs_busy),     32'd0);
    issue_rd = 5'd9;
    #1;
    chk("post reset issue_ready r9", 32'(issue_ready), 32'd1);
    fpu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    chk("post reset ptr fpu_ready", 32'(fpu_ready), 32'd1);
    chk("post reset ptr mem_ready", 32'(mem_ready), 32'd0);
    idle_inputs();

    // Randomized phase against the behavioural model
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    m_turn = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    begin
      bit f_acc = 1'b0, m_acc = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        bit e_f, e_m, e_ir, iss_ok;
        logic [2:0] e_rs;
        @(posedge clk); #1;
        if (!fpu_valid || f_acc) begin
          fpu_valid = ($urandom_range(0, 2) != 0);
          fpu_rd    = 5'($urandom_range(0, 7));
          fpu_wdata = $urandom;
        end
        if (!mem_valid || m_acc) begin
          mem_valid = ($urandom_range(0, 2) != 0);
          mem_rd    = 5'($urandom_range(0, 7));
          mem_wdata = $urandom;
        end
        issue_valid = ($urandom_range(0, 1) != 0);
        issue_rd    = 5'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++) rs_addr[k] = 5'($urandom_range(0, 7));
        @(negedge clk);
        if (fpu_valid && mem_valid) begin
          e_f = (m_turn == 0); e_m = (m_turn == 1);
        end else begin
          e_f = fpu_valid; e_m = mem_valid;
        end
        e_ir = !m_busy[issue_rd];
        for (int k = 0; k < 3; k++) e_rs[k] = m_busy[rs_addr[k]];
        chk($sformatf("rnd%0d fpu_ready", cyc),   32'(fpu_ready),   32'(e_f));
        chk($sformatf("rnd%0d mem_ready", cyc),   32'(mem_ready),   32'(e_m));
        chk($sformatf("rnd%0d we", cyc),          32'(we),          32'(m_we));
        chk($sformatf("rnd%0d waddr", cyc),       32'(waddr),       32'(m_waddr));
        chk($sformatf("rnd%0d wdata", cyc),       wdata,            m_wdata);
        chk($sformatf("rnd%0d issue_ready", cyc), 32'(issue_ready), 32'(e_ir));
        chk($sformatf("rnd%0d rs_busy", cyc),     32'(rs_busy),     32'(e_rs));
        // Advance the model across the coming edge
        iss_ok = issue_valid && e_ir;
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (iss_ok) m_busy[issue_rd] = 1'b1;
        if (fpu_valid && mem_valid) m_turn = 1 - m_turn;
        m_we = e_f || e_m;
        if (e_f) begin
          m_waddr = fpu_rd; m_wdata = fpu_wdata;
        end else if (e_m) begin
          m_waddr = mem_rd; m_wdata = mem_wdata;
        end
        f_acc = e_f; m_acc = e_m;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_ss_wb_arbiter.md
# fpu_ss_wb_arbiter

Write-back arbiter and register scoreboard for the FPU subsystem's single-write-port floating-point register file. It merges two write-back requesters, FPU results and FP loads from memory, onto the one register-file write port, and registers the winning write for one cycle. It also tracks which FP registers have a write in flight, so the issue logic can stall on RAW/WAW hazards.

## Interface
Parameters:
- NumRegs, 32, number of FP registers tracked; must equal register-file depth.
- AddrWidth, 5, register address width, $clog2(NumRegs).
- DataWidth, 32, write data width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- fpu_valid_i / fpu_ready_o  in/out  1  FPU result handshake.
- fpu_rd_i  in  AddrWidth  FPU destination register.
- fpu_wdata_i  in  DataWidth  FPU result.
- mem_valid_i / mem_ready_o  in/out  1  load write-back handshake.
- mem_rd_i  in  AddrWidth  load destination register.
- mem_wdata_i  in  DataWidth  load data.
- issue_valid_i  in  1  instruction with FP destination issuing this cycle.
- issue_rd_i  in  AddrWidth  its destination register.
- issue_ready_o  out  1  issue accepted (no WAW on issue_rd_i).
- rs_addr_i  in  3×AddrWidth  source addresses of the issuing instruction.
- rs_busy_o  out  3  per-source pending-write flag.
- we_o  out  1  register-file write enable.
- waddr_o  out  AddrWidth  register-file write address.
- wdata_o  out  DataWidth  register-file write data.

## Operation
- Handshake: a transfer occurs when valid & ready. A requester holds valid, rd and wdata stable until it is accepted.
- Arbitration:
  - Only one requester valid: it gets ready=1.
  - Both valid: a one-bit round-robin pointer picks the winner, and the loser sees ready=0.
  - The pointer flips only on a contended grant. After reset it favours fpu.
- Write stage: the granted rd and wdata are captured in output flops, and we_o=1 the following cycle. With no grant, we_o=0. waddr_o and wdata_o hold their last values.
- Scoreboard: a busy[NumRegs] vector.
  - Set: on issue_valid_i & issue_ready_o, busy[issue_rd_i] is set.
  - Clear: on we_o=1, busy[waddr_o] is cleared at the same edge the register file is written.
  - Same register set and cleared in one cycle: set wins.
- issue_ready_o = ~busy[issue_rd_i]. It is combinational and independent of issue_valid_i.
- rs_busy_o[k] = busy[rs_addr_i[k]]. It is combinational and unqualified; the issue logic masks unused sources.
- Write-back to a non-busy register: it is written normally, and the scoreboard is unchanged.
- Reset mid-operation:
  - busy clears to 0, and the pointer goes to fpu.
  - we_o, waddr_o and wdata_o go to 0.
  - Any in-flight captured write is dropped.

## Timing
- Handshake to write: 1 cycle. The register-file contents update at the end of the we_o cycle.
- busy clears at the same edge as the register write. A dependent read is hazard-free from the next cycle.
- Issue to busy visible: 1 cycle.
- Throughput: one write per cycle. A contended pair completes in 2 consecutive cycles.
- ready outputs depend combinationally only on the valid inputs and the pointer, never on ready inputs, so there are no combinational loops.
- Reset values: we_o=0, waddr_o=0, wdata_o=0. fpu_ready_o and mem_ready_o follow their valids. issue_ready_o=1 and rs_busy_o=0.

## Structure
- Shared package fpu_ss_pkg holds:
  - the register-address typedef (AddrWidth);
  - the requester enum (WB_FPU, WB_MEM);
  - the NumRegs constant.
- One sub-module is natural: fpu_ss_scoreboard, containing the busy vector, set/clear logic and lookup ports. The arbiter and write stage stay in the top module.

## Test plan
- Single FPU write: fpu_valid=1, rd=5, data=0x3F800000 → fpu_ready=1. Next cycle we_o=1, waddr=5, wdata=0x3F800000. The cycle after that, we_o=0.
- Contention: fpu (rd=1) and mem (rd=2) both valid for 2 cycles, fpu taken, fpu_valid dropped after its grant, mem_valid held until granted.
  - Required: fpu granted first, mem second, with we_o high 2 cycles (waddr 1 then 2).
  - Required: a following contended pair grants mem first.
- Scoreboard RAW:
  - Issue rd=7. Next cycle rs_addr[0]=7 → rs_busy[0]=1.
  - Load write-back of rd=7 → rs_busy[0]=1 during the we_o cycle and 0 the cycle after.
- WAW stall: with busy[3]=1, issue_rd=3 → issue_ready=0 until the write to reg 3 retires.
- Same-cycle set/clear: we_o writes reg 9 while reg 9 is issued → busy[9]=1 afterwards.
- Reset mid-flight: assert rst_ni=0 with a captured write and busy bits set → we_o=0 immediately, all rs_busy=0 and issue_ready=1 after release.
